// File: rtl/add_pkg.sv
// Shared defaults and configuration check for the pipelined adder.
package add_pkg;

    localparam int ADD_W      = 64;
    localparam int ADD_STAGES = 4;

    function automatic bit add_cfg_ok(input int w, input int stages);
        return (stages >= 1) && (stages <= w) && ((w % stages) == 0);
    endfunction

endpackage

// File: rtl/add_slice.sv
// One S-bit carry slice: registered sum and carry-out, loads only when en is high.
module add_slice #(
    parameter int S = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] sum,
    output logic         cout
);

    logic [S-1:0] sum_q, sum_d;
    logic         cout_q, cout_d;

    always_comb begin
        {cout_d, sum_d} = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, cin};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: rtl/add_pipe.sv
// Pipelined W-bit adder, STAGES cycles input to registered output, throughput 1.
// The whole pipe advances together; a stalled output holds every stage and drops in_ready.
module add_pipe
    import add_pkg::*;
#(
    parameter int W      = ADD_W,
    parameter int STAGES = ADD_STAGES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic         cout
);

    localparam int S = W / STAGES;

    if (!add_cfg_ok(W, STAGES)) begin : g_bad_cfg
        $fatal(1, "add_pipe: need 1 <= STAGES <= W and W a multiple of STAGES");
    end

    logic                    adv;
    logic                    acc;
    logic [STAGES-1:0]       vld_q, vld_d;
    logic [STAGES-1:0][S-1:0] res;
    logic [STAGES-1:0]       carry;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign acc      = in_valid && adv;

    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d[0] = acc;
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [S-1:0] op_a, op_b, sum;
        logic         c_in;

        if (k == 0) begin : g_in0
            assign op_a = a[S-1:0];
            assign op_b = b[S-1:0];
            assign c_in = cin;
        end else begin : g_skew
            // Operand slice k waits k cycles so it meets slice k-1's carry.
            logic [S-1:0] a_sk_q [k];
            logic [S-1:0] b_sk_q [k];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < k; i++) begin
                        a_sk_q[i] <= '0;
                        b_sk_q[i] <= '0;
                    end
                end else if (adv) begin
                    a_sk_q[0] <= a[k*S +: S];
                    b_sk_q[0] <= b[k*S +: S];
                    for (int i = 1; i < k; i++) begin
                        a_sk_q[i] <= a_sk_q[i-1];
                        b_sk_q[i] <= b_sk_q[i-1];
                    end
                end
            end

            assign op_a = a_sk_q[k-1];
            assign op_b = b_sk_q[k-1];
            assign c_in = carry[k-1];
        end

        add_slice #(.S(S)) u_slice (
            .clk   (clk),
            .reset (reset),
            .en    (adv),
            .a     (op_a),
            .b     (op_b),
            .cin   (c_in),
            .sum   (sum),
            .cout  (carry[k])
        );

        if (k == STAGES-1) begin : g_last
            assign res[k] = sum;
        end else begin : g_deskew
            logic [S-1:0] ds_q [STAGES-1-k];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < STAGES-1-k; i++) begin
                        ds_q[i] <= '0;
                    end
                end else if (adv) begin
                    ds_q[0] <= sum;
                    for (int i = 1; i < STAGES-1-k; i++) begin
                        ds_q[i] <= ds_q[i-1];
                    end
                end
            end

            assign res[k] = ds_q[STAGES-2-k];
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign q         = res;
    assign cout      = carry[STAGES-1];

endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised pipelined adder, the next generation of the single-register 64-bit adder. It computes q = a + b + cin with a carry-out. The carry chain is split into STAGES equal slices, one slice per pipeline stage, so the critical path shrinks as STAGES grows. A valid/ready handshake provides throughput-1 streaming with backpressure; it sits between operand producers and result consumers in the add-tree datapath.

## Interface
- W, 64, operand and result width; W % STAGES == 0 is required.
- STAGES, 4, number of pipeline stages, 1..W; slice width S = W/STAGES.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in_valid  in  1  operands a, b, cin present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  q/cout hold a valid result.
- out_ready  in  1  consumer accepts the result this cycle.
- q  out  W  sum, (a + b + cin) mod 2^W.
- cout  out  1  carry out of bit W-1.

## Operation
- Global advance enable: adv = !out_valid || out_ready; in_ready = adv (combinational).
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- When adv = 1, every stage register loads and the valid bits shift by one. A stage-0 valid bit is set only on a transfer in; otherwise a bubble enters.
- When adv = 0, all registers hold, and q, cout and out_valid stay stable.
- Slice k (0..STAGES-1) adds bits [k*S +: S] of a and b plus a carry.
  - Slice 0 uses cin.
  - Slice k>0 uses the carry registered by slice k-1 in the previous stage.
- Operand slice k travels through k skew registers before being added.
- Result slice k travels through STAGES-1-k deskew registers after being added, so all slices of one transaction reach the output together.
- cout is the registered carry of slice STAGES-1.
- Arithmetic is unsigned modulo 2^W; signed callers interpret q as two's complement, and cout is then not an overflow flag.
- STAGES = 1: a single registered W-bit adder with the handshake.
- Bubbles do not collapse. The pipeline advances as a whole.

## Timing
- Reset values:
  - all valid bits 0, so out_valid = 0;
  - q = 0, cout = 0;
  - all skew, deskew and carry registers 0.
- in_ready is 1 during and immediately after reset, because out_valid = 0. Operands presented in a reset cycle are discarded.
- Reset mid-operation: every in-flight transaction is dropped. The cycle after reset deasserts has out_valid = 0.
- Latency: a transaction accepted at edge n appears with out_valid = 1 after edge n+STAGES-1, i.e. STAGES cycles from input to registered output, provided adv = 1 throughout.
- Throughput: one transaction per cycle while out_ready = 1.
- Stall: if out_valid && !out_ready, in_ready = 0 in the same cycle, and nothing is accepted or lost.
- Simultaneous transfer in and transfer out in the same cycle is legal and is the steady state.

## Structure
- Package add_pkg holds:
  - localparam defaults ADD_W = 64 and ADD_STAGES = 4;
  - a function checking W % STAGES == 0, used in an elaboration-time assertion.
- Sub-module add_slice is parametrised by S and is instantiated STAGES times with a generate loop. Its inputs are an S-bit a, an S-bit b, cin and en. It has registered sum[S] and cout with synchronous reset.
- The top level owns the skew/deskew shift registers, the valid chain and the handshake.

## Test plan
- W=64, STAGES=4: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> q=0, cout=1, out_valid high 4 cycles after acceptance. This checks carry rippling across all slices.
- W=64, STAGES=4: a=b=0, cin=1 -> q=1, cout=0. Then 16 back-to-back random pairs with out_ready=1 -> 16 consecutive results matching a+b+cin, in order, with no gaps.
- Stall: stream 6 transactions, drop out_ready for 5 cycles mid-stream -> q/cout stable while stalled, in_ready=0, and all 6 results delivered exactly once, in order.
- Reset asserted for 1 cycle with 3 transactions in flight -> out_valid=0 and q=0 the next cycle, none of the 3 ever emitted, and the next accepted pair yields a correct sum after 4 cycles.
- W=8, STAGES=1: a=0x80, b=0x80, cin=0 -> q=0x00, cout=1, 1 cycle latency.
- W=8, STAGES=8: a=0x7F, b=0x01, cin=0 -> q=0x80, cout=0, 8 cycle latency. Then a=0xFF, b=0xFF, cin=1 -> q=0xFF, cout=1.
